// File: rtl/memsched_defs_pkg.sv
// Shared definitions for the memory-side scheduling blocks: FSM state
// encodings, default widths and a counter-width helper.
package memsched_defs_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } mem_state_e;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_WAIT_STATES = 2;

  // Width of a down-counter that must hold wait_states; never narrower than 1 bit.
  function automatic int cnt_width(input int wait_states);
    if (wait_states < 1) return 1;
    return $clog2(wait_states + 1);
  endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Two-way round-robin selector. The last-grant input is 0 for port 1 and
// 1 for port 2; on a tie the port that was not granted last wins.
module mem_rr_pick (
  input  logic req1_i,
  input  logic req2_i,
  input  logic last_i,
  output logic valid_o,
  output logic id_o
);

  // Pick a port: a lone requester wins outright, a tie goes to the other port.
  always_comb begin
    valid_o = req1_i | req2_i;
    id_o    = 1'b0;
    if (req1_i && req2_i) begin
      id_o = ~last_i;
    end else if (req2_i) begin
      id_o = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-ported memory. Each access is
// granted round-robin, held for WAIT_STATES+1 enable cycles, and finished
// with a one-cycle done pulse to the granted port.
// Optional build macro ARB_PERF_CNT_EN adds saturating per-port
// completed-access counters on outputs cnt1/cnt2.
module mem_port_arbiter
  import memsched_defs_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              write1,
  input  logic [DATA_W-1:0] dat1,
  output logic              wait1,
  output logic              done1,
  output logic [DATA_W-1:0] rdat1,
  input  logic              req2,
  input  logic [ADDR_W-1:0] addr2,
  input  logic              write2,
  input  logic [DATA_W-1:0] dat2,
  output logic              wait2,
  output logic              done2,
  output logic [DATA_W-1:0] rdat2,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdat,
  input  logic [DATA_W-1:0] mem_rdat
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]       cnt1,
  output logic [15:0]       cnt2
`endif
);

  localparam int CNT_W = cnt_width(WAIT_STATES);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [DATA_W-1:0] rdat1_q, rdat1_d;
  logic [DATA_W-1:0] rdat2_q, rdat2_d;
  logic              pick_valid;
  logic              pick_id;

  mem_rr_pick u_pick (
    .req1_i  (req1),
    .req2_i  (req2),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .id_o    (pick_id)
  );

  // State and datapath registers; the last-grant pointer starts at port 2
  // so port 1 wins the first tie after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdat1_q <= '0;
      rdat2_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdat1_q <= rdat1_d;
      rdat2_q <= rdat2_d;
    end
  end

  // Next-state: latch the winner's request in IDLE, count down the access,
  // capture read data on the final access cycle, then pulse done once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rdat1_d = rdat1_q;
    rdat2_d = rdat2_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_id;
          last_d  = pick_id;
          addr_d  = pick_id ? addr2  : addr1;
          wdat_d  = pick_id ? dat2   : dat1;
          we_d    = pick_id ? write2 : write1;
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (gnt_q) rdat2_d = mem_rdat;
            else       rdat1_d = mem_rdat;
          end
          state_d = COMPLETE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      COMPLETE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_en   = (state_q == ACCESS);
  assign mem_we   = (state_q == ACCESS) && we_q;
  assign mem_addr = addr_q;
  assign mem_wdat = wdat_q;
  assign done1    = (state_q == COMPLETE) && !gnt_q;
  assign done2    = (state_q == COMPLETE) &&  gnt_q;
  assign wait1    = req1 & ~done1;
  assign wait2    = req2 & ~done2;
  assign rdat1    = rdat1_q;
  assign rdat2    = rdat2_q;

`ifdef ARB_PERF_CNT_EN
  logic [15:0] cnt1_q, cnt2_q;

  // Saturating completed-access counters, one per port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else begin
      if (done1 && (cnt1_q != 16'hFFFF)) cnt1_q <= cnt1_q + 16'd1;
      if (done2 && (cnt2_q != 16'hFFFF)) cnt2_q <= cnt2_q + 16'd1;
    end
  end

  assign cnt1 = cnt1_q;
  assign cnt2 = cnt2_q;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported 16-bit memory between two requesters (port 1 and port 2, e.g. instruction fetch and data access). Uses round-robin arbitration and a fixed, parameterised access time. Holds the losing requester with a wait signal, latches the request, sequences the memory enable and write strobe, and returns read data with a one-cycle done pulse. Sits between the core-side address/data ports and the memory macro.

Parameters:
ADDR_W, 32, address width of requester and memory ports
DATA_W, 16, data width
WAIT_STATES, 2, extra memory cycles per access; access phase lasts WAIT_STATES+1 cycles; 0 is legal

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
req1  input  1  port 1 request, level; held until done1
addr1  input  ADDR_W  port 1 address
write1  input  1  port 1: 1=write, 0=read
dat1  input  DATA_W  port 1 write data
wait1  output  1  port 1 stall
done1  output  1  port 1 access complete, one-cycle pulse
rdat1  output  DATA_W  port 1 read data, registered
req2, addr2, write2, dat2, wait2, done2, rdat2: same as port 1, for port 2
mem_en  output  1  memory access active
mem_we  output  1  memory write strobe
mem_addr  output  ADDR_W  memory address, registered
mem_wdat  output  DATA_W  memory write data, registered
mem_rdat  input  DATA_W  memory read data, valid in last access cycle

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; mem_en=0, mem_we=0, mem_addr=0, mem_wdat=0; done1=done2=0; rdat1=rdat2=0; last-grant pointer=2, so port 1 wins the first tie. A write in flight is truncated; no completion is reported.
- States: IDLE, ACCESS, COMPLETE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the port not granted last.
  - On a grant, at the clock edge: latch addr, dat and write into mem_addr, mem_wdat and the write flag; load the counter with WAIT_STATES; record the grant; go to ACCESS.
- ACCESS:
  - mem_en=1; mem_we=latched write flag.
  - Counter decrements each cycle.
  - When the counter is 0 at an edge: for a read, register mem_rdat into rdat of the granted port; go to COMPLETE.
- COMPLETE:
  - done of the granted port =1 for exactly this cycle; mem_en=0, mem_we=0; then go to IDLE.
- Latency: request high before edge E0 in IDLE → ACCESS over cycles E0..E0+WAIT_STATES+1 → done high in the following cycle.
  - WAIT_STATES=2: done in cycle E3–E4.
  - Back-to-back throughput: one access per WAIT_STATES+3 cycles.
- waitN = reqN & ~doneN (combinational). A requester sees wait drop in its done cycle and may present a new request at the next edge.
- rdatN changes only on read completion for that port. Writes and the other port's accesses leave it unchanged.
- mem_addr and mem_wdat hold their last values while idle.
- Request dropped mid-access: the access still completes, done still pulses, and rdat updates on a read. Changes to addr, dat or write after the grant are ignored.
- Simultaneous new requests in IDLE: round-robin only. Strict alternation under continuous contention; no starvation.
- Counter width: clog2(WAIT_STATES+1), minimum 1 bit.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined: adds outputs cnt1 and cnt2 (16 bits each). Each counts completed accesses for its port, incrementing on doneN and saturating at 0xFFFF. Both reset to 0.
- When undefined: the ports and the logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared header memsched_defs: state encodings (IDLE=2'd0, ACCESS=2'd1, COMPLETE=2'd2) and default width constants; reused by the other memory-side blocks.
- One sub-module, mem_rr_pick: combinational 2-way round-robin selector. Inputs: req1, req2, last-grant pointer. Outputs: grant valid and grant id.

Test Plan:
- Single read, WAIT_STATES=2: req1 with addr1=0x100, memory returns 0xBEEF. Expect mem_en high for 3 cycles, done1 in the 4th cycle, rdat1=0xBEEF, wait1 high until the done1 cycle.
- Single write: req2 with write2=1, addr2=0x20, dat2=0x1234. Expect mem_we=1 for 3 cycles with mem_addr=0x20 and mem_wdat=0x1234; done2 pulses once; rdat2 unchanged.
- Contention from reset: req1 and req2 both high continuously for 4 accesses. Expect grant order 1,2,1,2, with wait held on the non-granted port.
- WAIT_STATES=0: read. Expect mem_en for 1 cycle and done in the next; back-to-back period 3 cycles.
- Reset mid-access: rst low in the 2nd ACCESS cycle. Expect mem_en=mem_we=0 immediately and no done. After release, req1 and req2 both high → port 1 granted first.
- Drop req1 in the 1st ACCESS cycle of a read. Expect the access to complete, done1 to pulse, and rdat1 to update. With ARB_PERF_CNT_EN defined, cnt1 increments by 1.
